// File: rtl/mem_ctrl_dual.sv
// Dual-channel (fetch + load/store) byte-serial memory controller.
// Optional macro MC_IO_THROTTLE_EN withholds IO stores while io_buffer_full.
module mem_ctrl_dual #(
  parameter int LINE_BYTES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  input  logic                    io_buffer_full,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_valid,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [1:0]              ls_size,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_valid,
  output logic [31:0]             ls_rdata
);

  localparam int LW = 8 * LINE_BYTES;
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     nb_q, nb_d;
  logic [CW-1:0]     idx;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ls_q, ls_d;
  logic              wr_q, wr_d;
  logic [LW-1:0]     buf_q, buf_d;
  logic              ls_ok;
  logic              last;

`ifdef MC_IO_THROTTLE_EN
  assign ls_ok = ls_req &&
    !(ls_we && (ls_addr[17:16] == 2'b11) && io_buffer_full);
`else
  logic unused_full;
  assign unused_full = io_buffer_full;
  assign ls_ok = ls_req;
`endif

  // Next state, request latch, read assembly and bus outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nb_d     = nb_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    ls_d     = ls_q;
    wr_d     = wr_q;
    buf_d    = buf_q;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    if_valid = 1'b0;
    ls_valid = 1'b0;
    idx      = cnt_q - 1'b1;
    last     = wr_q ? (cnt_q == nb_q - 1'b1) : (cnt_q == nb_q);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        buf_d = '0;
        if (ls_ok) begin
          ls_d    = 1'b1;
          wr_d    = ls_we;
          base_d  = ls_addr;
          wdata_d = ls_wdata;
          unique case (ls_size)
            2'd0:    nb_d = CW'(1);
            2'd1:    nb_d = CW'(2);
            default: nb_d = CW'(4);
          endcase
          state_d = BUSY;
        end else if (if_req) begin
          ls_d    = 1'b0;
          wr_d    = 1'b0;
          base_d  = if_addr;
          wdata_d = '0;
          nb_d    = CW'(LINE_BYTES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wr_q) begin
          mem_wr   = 1'b1;
          mem_a    = base_q + ADDR_W'(cnt_q);
          mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else begin
          if (cnt_q < nb_q)
            mem_a = base_q + ADDR_W'(cnt_q);
          if (cnt_q != '0)
            buf_d[{idx, 3'b000} +: 8] = mem_din;
        end
        if (last)
          state_d = DONE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        if_valid = !ls_q;
        ls_valid = ls_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nb_q    <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      ls_q    <= 1'b0;
      wr_q    <= 1'b0;
      buf_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      ls_q    <= ls_d;
      wr_q    <= wr_d;
      buf_q   <= buf_d;
    end
  end

  // Result registers only update when a read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy && state_q == BUSY && last && !wr_q) begin
      if (ls_q)
        ls_rdata <= buf_d[31:0];
      else
        if_data <= buf_d;
    end
  end

endmodule
